fei4_data_tx: RTL and testbench
===============================

FEI4_DATA_TX -- requirements
Module: fei4_data_tx

Interface
REQ-001 SHALL provide parameter IDLE_CHAR, default 8'hBC (K28.5), meaning the K character sent when no data is accepted.
REQ-002 SHALL provide parameter SOF_CHAR, default 8'hFC (K28.7), meaning the start-of-frame K code, reported only via the IS_SOF status.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLK  in  1  single clock; all logic on posedge.
REQ-005 RST_B  in  1  asynchronous active-low reset.
REQ-006 BIT_CE  in  1  serial bit enable; one bit shifted per cycle with BIT_CE=1.
REQ-007 ENABLE  in  1  1 = accept data; 0 = idle characters only.
REQ-008 DATA_IN  in  8  byte to send, HGFEDCBA.
REQ-009 K_IN  in  1  1 = DATA_IN is a K character.
REQ-010 VALID_IN  in  1  DATA_IN/K_IN valid.
REQ-011 READY_OUT  out  1  symbol slot open; transfer when VALID_IN & READY_OUT.
REQ-012 TX_DATA  out  1  serial 8b10b line, bit 'a' first.
REQ-013 RD_POS  out  1  current running disparity, 1 = RD+.
REQ-014 CODE_ERR  out  1  one-cycle pulse when an illegal K code was accepted.
REQ-015 IS_SOF  out  1  one-cycle pulse when SOF_CHAR with K_IN=1 is loaded.

Function
REQ-016 SHALL hold a 10-bit shift register and a bit counter 0..9; the counter advances and the register shifts only when BIT_CE=1.
REQ-017 SHALL assert READY_OUT combinationally when BIT_CE=1, bit counter=9 and ENABLE=1; otherwise READY_OUT SHALL be 0.
REQ-018 On a load slot (BIT_CE=1, count=9) with a transfer, SHALL encode DATA_IN/K_IN; without a transfer (including ENABLE=0), SHALL encode IDLE_CHAR as K.
REQ-019 SHALL drive the first bit ('a') of a loaded symbol on TX_DATA in the cycle after the load slot; each further bit follows on the next BIT_CE.
REQ-020 SHALL encode standard 5b/6b + 3b/4b with running disparity, including D.x.A7 alternate encoding and K28.x/K23.7/K27.7/K29.7/K30.7.
REQ-021 SHALL update RD_POS at the load slot from the disparity of the loaded symbol; neutral symbols SHALL leave RD_POS unchanged.
REQ-022 An illegal K code SHALL be replaced by IDLE_CHAR, count as accepted, and pulse CODE_ERR in the cycle after the load slot.
REQ-023 ENABLE deassertion mid-symbol SHALL complete the current symbol; subsequent slots carry IDLE_CHAR.
REQ-024 VALID_IN without READY_OUT SHALL have no effect; DATA_IN SHALL be sampled only on transfer.
REQ-025 BIT_CE tied high SHALL sustain one symbol every 10 cycles with no gap.

Reset
REQ-026 While RST_B=0: TX_DATA=0, READY_OUT=0, RD_POS=0 (RD-), CODE_ERR=0, IS_SOF=0, bit counter=9, shift register=0.
REQ-027 Reset mid-symbol SHALL abort the symbol; the first slot after release SHALL be a load slot.

Configuration
REQ-028 With FEI4_DATA_TX_ERRINJ_EN defined, SHALL add input ERR_INJ; ERR_INJ=1 at a load slot SHALL transmit the symbol encoded with the inverted RD and leave RD_POS unchanged.
REQ-029 Without FEI4_DATA_TX_ERRINJ_EN, the ERR_INJ port and its logic SHALL be absent.

Structure
REQ-030 K-code constants (K28_5, K28_7, K28_3) and the 5b/6b and 3b/4b tables SHALL reside in the shared package fei4_8b10b_pkg.
REQ-031 The encoder SHALL be the sub-module enc_8b10b (inputs data, K, RD in; outputs 10-bit code, RD out, K-illegal); shifting and handshaking stay in fei4_data_tx.

Verification
REQ-032 Reset, ENABLE=0, BIT_CE=1 -> TX_DATA repeats 0011111010, 1100000101 alternating; RD_POS toggles once per symbol.
REQ-033 From RD-, send D21.5 (8'hB5, K=0) -> 1010101010; RD_POS unchanged.
REQ-034 Frame FC(K), 8'h00, 8'hFF, 7C(K) with VALID_IN held -> one READY_OUT per 10 cycles, exact 8b10b codes, IS_SOF once, no idle between symbols.
REQ-035 BIT_CE=1 one cycle in four -> each bit held for 4 cycles; READY_OUT only on the 10th BIT_CE.
REQ-036 Send 8'h3C with K=1 (legal K28.1) then 8'h00 with K=1 (illegal) -> K28.1 sent normally; the second slot sends K28.5 and pulses CODE_ERR once.
REQ-037 RST_B low at bit 4 of a symbol -> outputs reach reset values immediately; after release, the first symbol is a K28.5 RD- symbol.

Source files
------------

// File: rtl/fei4_8b10b_pkg.sv
// rtl/fei4_8b10b_pkg.sv - 8b10b K-character constants and 5b/6b, 3b/4b code tables
package fei4_8b10b_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_7 = 8'hFC;
   localparam logic [7:0] K28_3 = 8'h7C;

   localparam logic [5:0] ENC6_K28   = 6'b001111;
   localparam logic [3:0] ENC4_A7    = 4'b0111;
   localparam logic [3:0] ENC4_KX7   = 4'b1000;

   // RD- forms (abcdei); the RD+ form is the complement for unbalanced codes and D.7
   function automatic logic [5:0] enc6(input logic [4:0] x);
      logic [5:0] c;
      case (x)
         5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
         5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;  5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
         5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
         5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
         5'd16: c = 6'b011011;  5'd17: c = 6'b100011;  5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
         5'd20: c = 6'b001011;  5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
         5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
         5'd28: c = 6'b001110;  5'd29: c = 6'b101110;  5'd30: c = 6'b011110;  default: c = 6'b101011;
      endcase
      return c;
   endfunction

   // RD- forms (fghj); y=7 gives the primary P7 code
   function automatic logic [3:0] enc4(input logic [2:0] y);
      logic [3:0] c;
      case (y)
         3'd0: c = 4'b1011;  3'd1: c = 4'b1001;  3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
         3'd4: c = 4'b1101;  3'd5: c = 4'b1010;  3'd6: c = 4'b0110;  default: c = 4'b1110;
      endcase
      return c;
   endfunction

   // K28.y fghj as sent after the RD- 001111 block
   function automatic logic [3:0] enc4_k28(input logic [2:0] y);
      logic [3:0] c;
      case (y)
         3'd0: c = 4'b0100;  3'd1: c = 4'b1001;  3'd2: c = 4'b0101;  3'd3: c = 4'b0011;
         3'd4: c = 4'b0010;  3'd5: c = 4'b1010;  3'd6: c = 4'b0110;  default: c = 4'b1000;
      endcase
      return c;
   endfunction

   function automatic logic [3:0] ones(input logic [9:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 10; i++) n = n + {3'd0, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/enc_8b10b.sv
// rtl/enc_8b10b.sv - combinational 8b10b symbol encoder with running disparity
module enc_8b10b
   import fei4_8b10b_pkg::*;
(
   input  logic [7:0] data,
   input  logic       k,
   input  logic       rd_in,
   output logic [9:0] code,
   output logic       rd_out,
   output logic       k_illegal
);

   logic [4:0] x;
   logic [2:0] y;
   logic [5:0] b6;
   logic [3:0] b4;
   logic       rd6;
   logic       k_legal;

   always_comb begin
      x         = data[4:0];
      y         = data[7:5];
      k_legal   = (x == 5'd28) ||
                  (y == 3'd7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
      k_illegal = k && !k_legal;
      b6        = enc6(x);
      b4        = enc4(y);
      rd6       = rd_in;
      code      = '0;
      if (k) begin
         // every K code at RD+ is the bitwise complement of its RD- form
         code = (x == 5'd28) ? {ENC6_K28, enc4_k28(y)} : {b6, ENC4_KX7};
         if (rd_in)
            code = ~code;
      end else begin
         if (rd_in && (ones({4'd0, b6}) != 4'd3 || x == 5'd7))
            b6 = ~b6;
         rd6 = (ones({4'd0, b6}) != 4'd3) ? ~rd_in : rd_in;
         // A7 avoids a run of five equal bits across the e/i/f/g/h boundary
         if (y == 3'd7 && ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                           ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
            b4 = ENC4_A7;
         if (rd6 && (ones({6'd0, b4}) != 4'd2 || y == 3'd3))
            b4 = ~b4;
         code = {b6, b4};
      end
      rd_out = (ones(code) != 4'd5) ? ~rd_in : rd_in;
   end

endmodule

// File: rtl/fei4_data_tx.sv
// rtl/fei4_data_tx.sv - 8b10b serial transmitter with byte handshake; FEI4_DATA_TX_ERRINJ_EN adds ERR_INJ
module fei4_data_tx
   import fei4_8b10b_pkg::*;
#(
   parameter logic [7:0] IDLE_CHAR = K28_5,
   parameter logic [7:0] SOF_CHAR  = K28_7
) (
   input  logic       CLK,
   input  logic       RST_B,
   input  logic       BIT_CE,
   input  logic       ENABLE,
   input  logic [7:0] DATA_IN,
   input  logic       K_IN,
   input  logic       VALID_IN,
`ifdef FEI4_DATA_TX_ERRINJ_EN
   input  logic       ERR_INJ,
`endif
   output logic       READY_OUT,
   output logic       TX_DATA,
   output logic       RD_POS,
   output logic       CODE_ERR,
   output logic       IS_SOF
);

   logic [3:0] bit_cnt;
   logic [9:0] shreg;
   logic       load;
   logic       xfer;
   logic       use_data;
   logic       rd_enc;
   logic       rd_next;
   logic [9:0] data_code;
   logic [9:0] idle_code;
   logic [9:0] sel_code;
   logic       data_rd;
   logic       idle_rd;
   logic       sel_rd;
   logic       data_k_illegal;
   logic       unused_idle_illegal;

   assign load      = BIT_CE && (bit_cnt == 4'd9);
   assign READY_OUT = RST_B && load && ENABLE;
   assign xfer      = VALID_IN && READY_OUT;
   assign use_data  = xfer && !data_k_illegal;
   assign sel_code  = use_data ? data_code : idle_code;
   assign sel_rd    = use_data ? data_rd : idle_rd;
   assign TX_DATA   = shreg[9];

`ifdef FEI4_DATA_TX_ERRINJ_EN
   // injected symbols use the wrong disparity column and leave the tracked RD alone
   assign rd_enc  = RD_POS ^ ERR_INJ;
   assign rd_next = ERR_INJ ? RD_POS : sel_rd;
`else
   assign rd_enc  = RD_POS;
   assign rd_next = sel_rd;
`endif

   enc_8b10b u_enc_data (
      .data      (DATA_IN),
      .k         (K_IN),
      .rd_in     (rd_enc),
      .code      (data_code),
      .rd_out    (data_rd),
      .k_illegal (data_k_illegal)
   );

   enc_8b10b u_enc_idle (
      .data      (IDLE_CHAR),
      .k         (1'b1),
      .rd_in     (rd_enc),
      .code      (idle_code),
      .rd_out    (idle_rd),
      .k_illegal (unused_idle_illegal)
   );

   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         bit_cnt  <= 4'd9;
         shreg    <= '0;
         RD_POS   <= 1'b0;
         CODE_ERR <= 1'b0;
         IS_SOF   <= 1'b0;
      end else begin
         CODE_ERR <= 1'b0;
         IS_SOF   <= 1'b0;
         if (BIT_CE) begin
            if (bit_cnt == 4'd9) begin
               shreg    <= sel_code;
               bit_cnt  <= 4'd0;
               RD_POS   <= rd_next;
               CODE_ERR <= xfer && data_k_illegal;
               IS_SOF   <= xfer && K_IN && (DATA_IN == SOF_CHAR);
            end else begin
               shreg   <= {shreg[8:0], 1'b0};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fei4_data_tx.sv
// tb/tb_fei4_data_tx.sv - self-checking bench for fei4_data_tx
module tb_fei4_data_tx;

   typedef struct {
      logic       en;
      logic       valid;
      logic       k;
      logic [7:0] data;
      logic [9:0] code;
      logic       rd;
      logic       err;
      logic       sof;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_b = 1'b0;
   logic       bit_ce = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       k_in = 1'b0;
   logic       valid_in = 1'b0;
   logic       ready_out, tx_data, rd_pos, code_err, is_sof;
`ifdef FEI4_DATA_TX_ERRINJ_EN
   logic       err_inj = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   logic [5:0] tab6 [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   logic [3:0] tab4 [8]  = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
   logic [3:0] k28_4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
   logic [7:0] legal_k [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                8'hF7, 8'hFB, 8'hFD, 8'hFE};

   fei4_data_tx dut (
      .CLK       (clk),
      .RST_B     (rst_b),
      .BIT_CE    (bit_ce),
      .ENABLE    (enable),
      .DATA_IN   (data_in),
      .K_IN      (k_in),
      .VALID_IN  (valid_in),
`ifdef FEI4_DATA_TX_ERRINJ_EN
      .ERR_INJ   (err_inj),
`endif
      .READY_OUT (ready_out),
      .TX_DATA   (tx_data),
      .RD_POS    (rd_pos),
      .CODE_ERR  (code_err),
      .IS_SOF    (is_sof)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%b expected=%b", name, got, exp);
      end
   endtask

   function automatic int pop(input logic [9:0] v);
      int n = 0;
      for (int i = 0; i < 10; i++) n += int'(v[i]);
      return n;
   endfunction

   function automatic logic has_run5(input logic [9:0] w);
      for (int i = 0; i <= 5; i++)
         if (w[i +: 5] == 5'b11111 || w[i +: 5] == 5'b00000) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic is_legal_k(input logic [7:0] d);
      foreach (legal_k[i]) if (legal_k[i] == d) return 1'b1;
      return 1'b0;
   endfunction

   // reference: pick whichever table form keeps the line balanced, then fix runs of five with A7
   function automatic logic [9:0] ref_code(input logic [7:0] d, input logic k, input logic rd);
      logic [4:0] x;
      logic [2:0] y;
      logic [5:0] s6;
      logic [3:0] s4;
      logic       rd6;
      logic [9:0] w;
      x = d[4:0];
      y = d[7:5];
      if (k) begin
         w = (x == 5'd28) ? {6'b001111, k28_4[y]} : {tab6[x], 4'b1000};
         return rd ? ~w : w;
      end
      if (pop(10'(tab6[x])) == 3 && x != 5'd7) s6 = tab6[x];
      else s6 = rd ? ~tab6[x] : tab6[x];
      rd6 = (pop(10'(s6)) == 3) ? rd : ~rd;
      if (pop(10'(tab4[y])) == 2 && y != 3'd3) s4 = tab4[y];
      else s4 = rd6 ? ~tab4[y] : tab4[y];
      w = {s6, s4};
      if (y == 3'd7 && has_run5(w)) w = {s6, rd6 ? 4'b1000 : 4'b0111};
      return w;
   endfunction

   task automatic do_reset();
      rst_b = 1'b0; bit_ce = 1'b1; enable = 1'b1; valid_in = 1'b1; k_in = 1'b0; data_in = 8'hB5;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.tx", 10'(tx_data), 10'd0);
      chk("rst.ready", 10'(ready_out), 10'd0);
      chk("rst.rd", 10'(rd_pos), 10'd0);
      chk("rst.pulses", 10'({code_err, is_sof}), 10'd0);
      rst_b = 1'b1;
   endtask

   // entered and left at posedge+1 with the bit counter on 9
   task automatic do_symbol(input vec_t v, input string tag);
      logic [9:0] got;
      enable = v.en; valid_in = v.valid; k_in = v.k; data_in = v.data;
      #1;
      chk({tag, ".ready"}, 10'(ready_out), 10'(v.en));
      @(posedge clk);
      #1;
      got = '0;
      got[9] = tx_data;
      chk({tag, ".rd"}, 10'(rd_pos), 10'(v.rd));
      chk({tag, ".code_err"}, 10'(code_err), 10'(v.err));
      chk({tag, ".is_sof"}, 10'(is_sof), 10'(v.sof));
      data_in = 8'($urandom);
      k_in = 1'($urandom);
      for (int i = 8; i >= 0; i--) begin
         @(posedge clk);
         #1;
         got[i] = tx_data;
         if (i == 8) chk({tag, ".pulse_end"}, 10'({code_err, is_sof}), 10'd0);
      end
      chk({tag, ".code"}, got, v.code);
   endtask

   initial begin
      vec_t vecs [16];
      vec_t v;
      logic [9:0] ce_code;
      int n;
      logic rd_m;

      vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 10'b0011111010, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h55, 10'b1100000101, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'hB5, 10'b1010101010, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'hFC, 10'b0011111000, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 10'b1001110100, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 10'b1010110001, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h7C, 10'b0011110011, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h3C, 10'b1100000110, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h00, 10'b0011111010, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'hEB, 10'b1101001000, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 8'hF1, 10'b1000110111, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 10'b1100000101, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h67, 10'b1110001100, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 8'hF7, 10'b1110101000, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 8'hE7, 10'b1110001110, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 8'hE7, 10'b0001110001, 1'b0, 1'b0, 1'b0};

      #2;
      do_reset();
      for (int i = 0; i < 16; i++) do_symbol(vecs[i], $sformatf("vec%0d", i));

      // reset in the middle of a symbol while RD is positive
      do_reset();
      do_symbol('{1'b0, 1'b0, 1'b0, 8'h00, 10'b0011111010, 1'b1, 1'b0, 1'b0}, "pre_abort");
      enable = 1'b1; valid_in = 1'b1; k_in = 1'b0; data_in = 8'hB5;
      #1;
      repeat (5) @(posedge clk);
      #1;
      chk("abort.bit4", 10'(tx_data), 10'd1);
      #3;
      rst_b = 1'b0;
      #1;
      chk("abort.tx", 10'(tx_data), 10'd0);
      chk("abort.ready", 10'(ready_out), 10'd0);
      chk("abort.rd", 10'(rd_pos), 10'd0);
      chk("abort.pulses", 10'({code_err, is_sof}), 10'd0);
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      do_symbol('{1'b0, 1'b1, 1'b0, 8'hB5, 10'b0011111010, 1'b1, 1'b0, 1'b0}, "post_abort");

      // bit enable one cycle in four
      do_reset();
      enable = 1'b1; valid_in = 1'b1; k_in = 1'b0; data_in = 8'h00;
      ce_code = 10'b1001110100;
      n = 0;
      for (int c = 0; c < 80; c++) begin
         bit_ce = (c % 4 == 0);
         #1;
         chk("ce4.ready", 10'(ready_out), 10'(bit_ce && (n % 10 == 0)));
         @(posedge clk);
         #1;
         if (bit_ce) n++;
         chk("ce4.bit", 10'(tx_data), 10'(ce_code[4'(9 - ((n - 1) % 10))]));
      end
      bit_ce = 1'b1;

      // randomized symbols against the reference model
      do_reset();
      rd_m = 1'b0;
      for (int s = 0; s < 60; s++) begin
         logic acc, bad;
         v.en    = ($urandom_range(0, 7) != 0);
         v.valid = ($urandom_range(0, 3) != 0);
         v.k     = ($urandom_range(0, 3) == 0);
         v.data  = 8'($urandom);
         if (v.k && $urandom_range(0, 2) != 0) v.data = legal_k[$urandom_range(0, 11)];
         acc = v.en && v.valid;
         bad = acc && v.k && !is_legal_k(v.data);
         v.code = (acc && !bad) ? ref_code(v.data, v.k, rd_m) : ref_code(8'hBC, 1'b1, rd_m);
         v.rd   = (pop(v.code) != 5) ? ~rd_m : rd_m;
         v.err  = bad;
         v.sof  = acc && v.k && (v.data == 8'hFC);
         do_symbol(v, $sformatf("rnd%0d", s));
         rd_m = v.rd;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
